pixel_writer: RTL and testbench
===============================

// Module: pixel_writer
// PURPOSE
//  Video output stage directly downstream of the DPU. Accepts 24-bit pixel
//  commands {X[23:16], Y[15:8], Colour[7:0]} (the DPU Kbus, strobed by outEnable)
//  into a small FIFO. Clips commands outside the screen and writes each in-range
//  pixel to the framebuffer through a request/acknowledge port. Lets the DPU keep
//  issuing pixels while the framebuffer memory stalls.
// PARAMETERS
//  FIFO_DEPTH  4    pixel command FIFO entries (power of 2, >=2)
//  SCREEN_W    160  visible width; X valid range 0..SCREEN_W-1
//  SCREEN_H    120  visible height; Y valid range 0..SCREEN_H-1
//  ADDR_W      15   framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  Kbus       in   24      pixel command {X, Y, Colour}
//  pix_valid  in   1       command present on Kbus this cycle
//  pix_ready  out  1       FIFO can accept; transfer = pix_valid & pix_ready
//  fb_addr    out  ADDR_W  framebuffer word address = Y*SCREEN_W + X
//  fb_data    out  8       colour to write
//  fb_we      out  1       write request, held until fb_ack
//  fb_ack     in   1       memory accepted write this cycle
//  busy       out  1       FIFO non-empty or FSM not IDLE
//  clip_cnt   out  8       count of dropped out-of-range pixels, saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, FSM->IDLE, fb_we=0, fb_addr=0,
//   fb_data=0, clip_cnt=0, busy=0, pix_ready=1 (after release). All outputs
//   drop immediately, including fb_we mid-write; in-flight and queued pixels lost.
//  FIFO: pix_ready = !full (registered-count based, no same-cycle bypass).
//   A push when full is impossible by protocol; pix_valid while !pix_ready is ignored.
//   Simultaneous push and pop is legal at any fill level except full; at full
//   only pop occurs. Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
//  FSM states:
//   IDLE : if FIFO non-empty, pop the head into the hold register -> CHECK.
//   CHECK: if X>=SCREEN_W or Y>=SCREEN_H: clip_cnt+=1 (saturating) -> IDLE.
//          else register fb_addr=Y*SCREEN_W+X (ADDR_W bits, unsigned),
//          fb_data=Colour, fb_we=1 -> WRITE.
//   WRITE: hold fb_we/fb_addr/fb_data stable; on fb_ack: fb_we=0 -> IDLE.
//  Latency: push at edge N (empty FIFO, FSM IDLE) -> pop at edge N+1 -> fb_we=1
//   after edge N+2. Minimum 3 cycles per in-range pixel (IDLE,CHECK,WRITE with
//   immediate ack); a clipped pixel takes 2 cycles.
//  fb_ack outside WRITE is ignored. fb_ack in the first WRITE cycle is valid.
//  fb_addr/fb_data keep the last written values while idle.
//  busy = (count!=0) | (state!=IDLE); combinational.
//  Boundaries: X=SCREEN_W-1, Y=SCREEN_H-1 is in range (addr 19199 default).
//   X=255 or Y=255 is clipped. clip_cnt holds at 255.
// TESTING
//  1 Reset: rst_n=0 while fb_we=1 -> fb_we=0 same cycle; after release
//    pix_ready=1, busy=0, clip_cnt=0.
//  2 Single pixel: Kbus=0x0A_05_3C, ack held 1 -> one write, fb_addr=810,
//    fb_data=0x3C, fb_we high exactly 1 cycle, 3 cycles after push.
//  3 Backpressure: fb_ack=0, push 5 pixels back to back -> pix_ready=0 after
//    4 accepted while the first is held in WRITE. Raise ack -> all 5 written in order.
//  4 Clipping: Kbus=0xA0_00_FF (X=160) and 0x00_78_01 (Y=120) -> no fb_we,
//    clip_cnt=2. 0x9F_77_07 -> fb_addr=19199.
//  5 Saturation: 300 out-of-range pixels -> clip_cnt=255.
//  6 Simultaneous push/pop at count=FIFO_DEPTH-1 -> count unchanged, order kept.
//    Scoreboard vs reference queue over 1000 random pixels with random fb_ack.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer: video output stage behind the DPU.
// Pixel commands {X, Y, Colour} are queued in a small FIFO. A three-state
// engine then pops each command and either drops it when it is off-screen
// (counting it in clip_cnt) or writes its colour to the framebuffer through
// a request/acknowledge port. The FIFO lets the DPU keep issuing pixels
// while the memory stalls.
module pixel_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       Kbus,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ack,
  output logic              busy,
  output logic [7:0]        clip_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [23:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [1:0]        state;
  logic [23:0]       hold;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [7:0]        hold_x;
  logic [7:0]        hold_y;
  logic              out_of_range;
  logic [ADDR_W-1:0] addr_calc;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign pix_ready = ~full;
  assign push      = pix_valid & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign busy      = ~empty | (state != IDLE);

  assign hold_x       = hold[23:16];
  assign hold_y       = hold[15:8];
  assign out_of_range = (32'(hold_x) >= 32'(SCREEN_W)) || (32'(hold_y) >= 32'(SCREEN_H));
  assign addr_calc    = ADDR_W'(hold_y) * ADDR_W'(SCREEN_W) + ADDR_W'(hold_x);

  // FIFO storage: payload only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Kbus;
    end
  end

  // FIFO pointers and fill count; full blocks push, so push+pop never happens at full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Engine: pop a command, clip or issue the write, then hold the request until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      clip_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold  <= mem[rd_ptr];
            state <= CHECK;
          end
        end
        CHECK: begin
          if (out_of_range) begin
            if (clip_cnt != 8'hFF) begin
              clip_cnt <= clip_cnt + 8'd1;
            end
            state <= IDLE;
          end else begin
            fb_addr <= addr_calc;
            fb_data <= hold[7:0];
            fb_we   <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (fb_ack) begin
            fb_we <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          fb_we <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed and randomized check of pixel_writer against a
// transaction-level reference model (a command queue plus an engine phase).
module tb_pixel_writer;

  localparam int FIFO_DEPTH = 4;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int ADDR_W     = 15;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [23:0]       Kbus      = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_we;
  logic              fb_ack    = 1'b0;
  logic              busy;
  logic [7:0]        clip_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit ack_rand  = 1'b0;
  bit ack_level = 1'b0;
  logic [ADDR_W-1:0] wlog[$];

  pixel_writer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Kbus(Kbus), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ack(fb_ack),
    .busy(busy), .clip_cnt(clip_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc++;

  // Memory acknowledge: either a fixed level or a coin flip each cycle.
  always @(posedge clk) begin
    #1;
    fb_ack = ack_rand ? 1'($urandom_range(0, 1)) : ack_level;
  end

  // Reference model state: queued commands, the command in hand and its phase.
  logic [23:0] mq[$];
  int          m_phase;
  logic [23:0] m_cur;
  int          m_clip;
  bit          m_we;
  int          m_addr;
  int          m_data;
  bit          m_take;
  int          m_old;
  int          mx;
  int          my;

  // Reference model: one command at a time, 1 cycle to fetch, 1 to judge, write until ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_cur   = '0;
      m_clip  = 0;
      m_we    = 1'b0;
      m_addr  = 0;
      m_data  = 0;
    end else begin
      m_take = pix_valid && (mq.size() < FIFO_DEPTH);
      m_old  = m_phase;
      if (m_old == 2 && fb_ack) begin
        m_we    = 1'b0;
        m_phase = 0;
      end
      if (m_old == 1) begin
        mx = int'(m_cur[23:16]);
        my = int'(m_cur[15:8]);
        if (mx >= SCREEN_W || my >= SCREEN_H) begin
          m_clip  = (m_clip < 255) ? m_clip + 1 : 255;
          m_phase = 0;
        end else begin
          m_addr  = my * SCREEN_W + mx;
          m_data  = int'(m_cur[7:0]);
          m_we    = 1'b1;
          m_phase = 2;
        end
      end
      if (m_old == 0 && mq.size() != 0) begin
        m_cur   = mq.pop_front();
        m_phase = 1;
      end
      if (m_take) begin
        mq.push_back(Kbus);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, plus a log of completed writes.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pix_ready", 32'(pix_ready), 32'(mq.size() < FIFO_DEPTH));
      checkOutput("busy", 32'(busy), 32'((mq.size() != 0) || (m_phase != 0)));
      checkOutput("fb_we", 32'(fb_we), 32'(m_we));
      checkOutput("fb_addr", 32'(fb_addr), 32'(m_addr));
      checkOutput("fb_data", 32'(fb_data), 32'(m_data));
      checkOutput("clip_cnt", 32'(clip_cnt), 32'(m_clip));
      if (fb_we && fb_ack) begin
        wlog.push_back(fb_addr);
      end
    end
  end

  // Present a command and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [23:0] cmd);
    bit acc;
    int n;
    Kbus      = cmd;
    pix_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic releaseBus();
    pix_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitWe(input logic level, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (fb_we !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fb_we !== level) checkOutput("we_timeout", 32'(fb_we), 32'(level));
  endtask

  task automatic doReset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wlog.delete();
  endtask

  logic [23:0] cmds3 [5] = '{24'h01_01_11, 24'h02_00_22, 24'h00_02_33, 24'h9F_00_44, 24'h0A_0A_55};
  int          addr3 [5] = '{161, 2, 320, 159, 1610};
  logic [23:0] cmds6 [5] = '{24'h03_00_01, 24'h04_00_02, 24'h05_00_03, 24'h06_00_04, 24'h07_01_05};
  int          addr6 [5] = '{3, 4, 5, 6, 167};

  // Directed scenarios followed by the randomized run.
  initial begin
    int push_cyc;
    int base;
    int exp_writes;
    int exp_clip;
    logic [7:0] x;
    logic [7:0] y;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset dropping an in-flight write.
    ack_level = 1'b0;
    applyStimulus(24'h14_0A_55);
    releaseBus();
    waitWe(1'b1, 20);
    checkOutput("we_before_reset", 32'(fb_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("we_in_reset", 32'(fb_we), 32'd0);
    checkOutput("busy_in_reset", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wlog.delete();
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(pix_ready), 32'd1);
    checkOutput("busy_after_reset", 32'(busy), 32'd0);
    checkOutput("clip_after_reset", 32'(clip_cnt), 32'd0);
    checkOutput("addr_after_reset", 32'(fb_addr), 32'd0);
    @(posedge clk);
    #1;

    // Single pixel with acknowledge held high.
    ack_level = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(24'h0A_05_3C);
    push_cyc = cyc;
    releaseBus();
    waitWe(1'b1, 20);
    checkOutput("latency_edges", 32'(cyc - push_cyc), 32'd2);
    checkOutput("single_addr", 32'(fb_addr), 32'd810);
    checkOutput("single_data", 32'(fb_data), 32'h3C);
    @(negedge clk);
    checkOutput("we_width", 32'(fb_we), 32'd0);
    waitIdle(20);
    checkOutput("single_count", 32'(wlog.size()), 32'd1);

    // Backpressure: memory stalls, five commands fill hold register plus FIFO.
    ack_level = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) applyStimulus(cmds3[i]);
    releaseBus();
    @(negedge clk);
    checkOutput("full_ready", 32'(pix_ready), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    ack_level = 1'b1;
    waitIdle(100);
    checkOutput("bp_count", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 5; i++) begin
      if (wlog.size() > i + 1) checkOutput("bp_order", 32'(wlog[i + 1]), 32'(addr3[i]));
    end

    // Clipping and the far-corner address.
    base = wlog.size();
    applyStimulus(24'hA0_00_FF);
    applyStimulus(24'h00_78_01);
    releaseBus();
    waitIdle(50);
    checkOutput("clip_two", 32'(clip_cnt), 32'd2);
    checkOutput("clip_no_write", 32'(wlog.size()), 32'(base));
    applyStimulus(24'h9F_77_07);
    releaseBus();
    waitIdle(50);
    checkOutput("corner_count", 32'(wlog.size()), 32'(base + 1));
    if (wlog.size() > 0) checkOutput("corner_addr", 32'(wlog[wlog.size() - 1]), 32'd19199);
    checkOutput("corner_data_held", 32'(fb_data), 32'd7);

    // Saturation of the clip counter.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        x = 8'($urandom_range(160, 255));
        y = 8'($urandom_range(0, 255));
      end else begin
        x = 8'($urandom_range(0, 159));
        y = 8'($urandom_range(120, 255));
      end
      applyStimulus({x, y, 8'($urandom)});
    end
    releaseBus();
    waitIdle(100);
    checkOutput("clip_saturated", 32'(clip_cnt), 32'd255);

    // Simultaneous push and pop with three entries queued.
    doReset();
    ack_level = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(cmds6[i]);
    releaseBus();
    waitWe(1'b1, 20);
    ack_level = 1'b1;
    waitWe(1'b0, 20);
    Kbus      = cmds6[4];
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    releaseBus();
    @(negedge clk);
    checkOutput("pushpop_ready", 32'(pix_ready), 32'd1);
    waitIdle(100);
    checkOutput("pushpop_count", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (wlog.size() > i) checkOutput("pushpop_order", 32'(wlog[i]), 32'(addr6[i]));
    end

    // Randomized traffic with random acknowledge.
    doReset();
    exp_writes = 0;
    exp_clip   = 0;
    ack_rand   = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 175));
      y = 8'($urandom_range(0, 130));
      if (x < SCREEN_W && y < SCREEN_H) exp_writes++;
      else exp_clip++;
      applyStimulus({x, y, 8'($urandom)});
      if ($urandom_range(0, 3) == 0) begin
        releaseBus();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    releaseBus();
    ack_rand  = 1'b0;
    ack_level = 1'b1;
    waitIdle(500);
    checkOutput("rand_writes", 32'(wlog.size()), 32'(exp_writes));
    checkOutput("rand_clip", 32'(clip_cnt), 32'((exp_clip > 255) ? 255 : exp_clip));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
